reg_scoreboard: RTL
===================

# reg_scoreboard

Per-register write scoreboard for the decode stage, directly downstream of the bypassing register file. Tracks how many issued but not yet written-back instructions target each of the 8 architectural registers. Stalls decode when a source operand has an outstanding writer that the register file's same-cycle write-to-read bypass cannot cover. Counts are released by the same writeback strobe/select that drives the register file write port.

## Interface

- CNT_W, 2, width of each per-register outstanding-write counter; max outstanding writes per register = 2^CNT_W - 1
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- issue_valid  in  1  decode presents an instruction this cycle
- rs_sel  in  3  first source register
- rs_use  in  1  instruction reads rs_sel
- rt_sel  in  3  second source register
- rt_use  in  1  instruction reads rt_sel
- dst_sel  in  3  destination register
- dst_we  in  1  instruction writes dst_sel
- wb_write  in  1  writeback commits a register write this cycle (same signal as the register file write enable)
- wb_sel  in  3  register written at writeback (same as the register file write select)
- flush  in  1  squash all in-flight writers; scoreboard returns to empty
- stall  out  1  combinational; decode must hold the instruction
- issue  out  1  combinational; the instruction is accepted this cycle
- busy  out  8  bit i = counter i nonzero, decoded from registered state
- err  out  1  sticky registered error flag

## Operation

- State: eight CNT_W-bit counters cnt[0..7] plus the err flag. No other state.
- hit(r) = wb_write & (wb_sel == r).
- Source blocked: src_blk(r) = (cnt[r] != 0) & ~(hit(r) & cnt[r] == 1). Exactly one outstanding writer, retiring this cycle, is covered by the register file bypass. With two or more writers, the operand still blocks.
- Capacity blocked: dst_we & (cnt[dst_sel] == max).
- stall = issue_valid & ~flush & ((rs_use & src_blk(rs_sel)) | (rt_use & src_blk(rt_sel)) | capacity blocked).
- issue = issue_valid & ~flush & ~stall.
- Counter update per register r: inc = issue & dst_we & (dst_sel == r); dec = hit(r).
  - inc & dec: hold.
  - inc only: +1. Capacity stall guarantees no overflow.
  - dec only, cnt > 0: -1.
  - dec only, cnt == 0: hold at 0, set err (underflow, a writeback with no recorded writer).
- flush: all counters go to 0 next edge. Issue and wb_write are ignored that cycle, and flush never sets err. err is not cleared by flush.
- err is cleared only by rst.
- Register 0 has no special treatment; it is tracked like any other register.

## Timing

- Reset (rst low, asynchronous): all cnt = 0, err = 0. Outputs during and after reset: busy = 8'h00, err = 0. stall and issue follow the inputs with all counters at zero, so stall = 0 and issue = issue_valid & ~flush.
- stall and issue are combinational, with the same-cycle path from issue_valid, rs_sel, rt_sel, dst_sel, wb_write, wb_sel and flush.
- An accepted write is visible in busy and blocks dependents from the next cycle.
- A writeback releases the dependent in the same cycle through the bypass exemption. busy clears the following cycle.
- Reset asserted mid-sequence discards all counts immediately. The first edge after rst deasserts sees an empty scoreboard.

## Test plan

- Reset, then issue dst_sel=3 dst_we=1 -> issue=1; next cycle busy=8'h08. Then rs_sel=3 rs_use=1 -> stall=1, issue=0.
- busy=8'h08 with cnt[3]=1; present rs_sel=3 together with wb_write=1 wb_sel=3 -> stall=0, issue=1; next cycle busy=8'h00.
- Issue three writes to r5 (CNT_W=2) -> cnt[5]=3; a fourth dst_sel=5 -> stall=1. Same cycle with wb_write wb_sel=5 -> still stall (cnt 3); after one writeback, the fourth write issues and cnt stays 3.
- cnt[2]=2, then wb_sel=2 and rt_sel=2 rt_use=1 -> stall=1. Next cycle, cnt[2]=1 with a second writeback -> stall=0.
- Simultaneous issue dst_sel=1 and wb_write wb_sel=1 with cnt[1]=1 -> cnt[1] stays 1, busy bit1=1.
- wb_write wb_sel=6 with cnt[6]=0 -> err=1 next cycle and stays set. Then flush with busy=8'hFF -> busy=8'h00 next cycle, err still 1. Then rst low -> err=0 immediately.

Source files
------------

// File: rtl/reg_scoreboard.sv
// Per-register outstanding-write scoreboard for decode. It counts issued but
// not yet written-back writers of each of the 8 registers and stalls dependents.
module reg_scoreboard #(
  parameter int CNT_W = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_issue_valid,
  input  logic [2:0] i_rs_sel,
  input  logic       i_rs_use,
  input  logic [2:0] i_rt_sel,
  input  logic       i_rt_use,
  input  logic [2:0] i_dst_sel,
  input  logic       i_dst_we,
  input  logic       i_wb_write,
  input  logic [2:0] i_wb_sel,
  input  logic       i_flush,
  output logic       o_stall,
  output logic       o_issue,
  output logic [7:0] o_busy,
  output logic       o_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_cnt [8];
  logic             r_err;

  logic [7:0] w_hit;
  logic [7:0] w_blk;
  logic [7:0] w_inc;
  logic       w_cap_blk;
  logic       w_stall;
  logic       w_issue;

  // A lone writer retiring this cycle is covered by the register file bypass.
  always_comb begin
    w_hit = '0;
    w_blk = '0;
    for (int r = 0; r < 8; r++) begin
      w_hit[r] = i_wb_write & (i_wb_sel == 3'(r));
      w_blk[r] = (r_cnt[r] != '0) & ~(w_hit[r] & (r_cnt[r] == CNT_ONE));
    end
  end

  always_comb begin
    w_cap_blk = i_dst_we & (r_cnt[i_dst_sel] == CNT_MAX);
    w_stall   = i_issue_valid & ~i_flush &
                ((i_rs_use & w_blk[i_rs_sel]) |
                 (i_rt_use & w_blk[i_rt_sel]) |
                 w_cap_blk);
    w_issue   = i_issue_valid & ~i_flush & ~w_stall;
    w_inc     = '0;
    for (int r = 0; r < 8; r++) begin
      w_inc[r] = w_issue & i_dst_we & (i_dst_sel == 3'(r));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 8; r++) r_cnt[r] <= '0;
      r_err <= 1'b0;
    end else if (i_flush) begin
      for (int r = 0; r < 8; r++) r_cnt[r] <= '0;
    end else begin
      for (int r = 0; r < 8; r++) begin
        if (w_inc[r] && !w_hit[r]) begin
          r_cnt[r] <= r_cnt[r] + CNT_ONE;
        end else if (w_hit[r] && !w_inc[r]) begin
          // A writeback with no recorded writer is an underflow.
          if (r_cnt[r] == '0) r_err <= 1'b1;
          else                r_cnt[r] <= r_cnt[r] - CNT_ONE;
        end
      end
    end
  end

  always_comb begin
    o_busy = '0;
    for (int r = 0; r < 8; r++) o_busy[r] = (r_cnt[r] != '0);
  end

  assign o_stall = w_stall;
  assign o_issue = w_issue;
  assign o_err   = r_err;

endmodule
